// File: rtl/pio_decode_stage.sv
// PIO instruction decode stage shared by several state machines: splits each instruction
// into opcode/operands/side-set/delay and enforces each SM's post-issue delay.
module pio_decode_stage #(
    parameter int NUM_SM = 4,
    parameter int SM_W   = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           in_instr,
    input  logic [SM_W-1:0]       in_sm,
    input  logic [3*NUM_SM-1:0]   cfg_sideset_bits,
    input  logic [NUM_SM-1:0]     cfg_sideset_en,
    input  logic [NUM_SM-1:0]     sm_enable,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SM_W-1:0]       out_sm,
    output logic [2:0]            out_op,
    output logic [2:0]            out_op1,
    output logic [4:0]            out_op2,
    output logic [4:0]            out_side_set,
    output logic                  out_side_valid,
    output logic [4:0]            out_delay,
    output logic [NUM_SM-1:0]     sm_busy
);

    typedef struct packed {
        logic [4:0] side_set;
        logic       side_valid;
        logic [4:0] delay;
    } dec_t;

    // The 5-bit delay/side-set field is shared: side-set takes the top S bits, delay the rest.
    function automatic dec_t decode_f(input logic [4:0] f, input logic [2:0] bits, input logic en);
        logic [2:0] s;
        logic [2:0] sh;
        dec_t       d;
        s       = (bits > 3'd5) ? 3'd5 : bits;
        sh      = 3'd5 - s;
        d.delay = f & (5'h1f >> s);
        if (en && (s != 3'd0)) begin
            d.side_valid = f[4];
            d.side_set   = (f >> sh) & (5'h0f >> sh);
        end else begin
            d.side_valid = (s != 3'd0);
            d.side_set   = f >> sh;
        end
        return d;
    endfunction

    logic [4:0]       cnt_r [NUM_SM];
    logic             out_valid_r;
    logic [SM_W-1:0]  out_sm_r;
    logic [2:0]       out_op_r;
    logic [2:0]       out_op1_r;
    logic [4:0]       out_op2_r;
    logic [4:0]       out_side_set_r;
    logic             out_side_valid_r;
    logic [4:0]       out_delay_r;

    logic             sel_hit_s;
    logic [2:0]       sel_bits_s;
    logic             sel_en_s;
    logic             sel_enable_s;
    logic             sel_busy_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             xfer_s;
    logic [NUM_SM-1:0] busy_s;
    dec_t             dec_s;

    // Per-SM busy flags from the delay counters.
    always_comb begin
        busy_s = '0;
        for (int k = 0; k < NUM_SM; k++) begin
            busy_s[k] = (cnt_r[k] != 5'd0);
        end
    end

    // Gather the issuing SM's config and status; an out-of-range index matches nothing.
    always_comb begin
        sel_hit_s    = 1'b0;
        sel_bits_s   = 3'd0;
        sel_en_s     = 1'b0;
        sel_enable_s = 1'b0;
        sel_busy_s   = 1'b0;
        for (int k = 0; k < NUM_SM; k++) begin
            logic hit;
            hit          = (in_sm == SM_W'(k));
            sel_hit_s    = sel_hit_s | hit;
            sel_bits_s   = sel_bits_s | ({3{hit}} & cfg_sideset_bits[3*k +: 3]);
            sel_en_s     = sel_en_s | (hit & cfg_sideset_en[k]);
            sel_enable_s = sel_enable_s | (hit & sm_enable[k]);
            sel_busy_s   = sel_busy_s | (hit & busy_s[k]);
        end
    end

    // Handshake: same-SM back-to-back issue only when the held instruction has no delay.
    always_comb begin
        in_ready_s = resetn && sel_hit_s && sel_enable_s && !sel_busy_s &&
                     (!out_valid_r ||
                      (out_ready && !((out_sm_r == in_sm) && (out_delay_r != 5'd0))));
        accept_s   = in_valid && in_ready_s;
        xfer_s     = out_valid_r && out_ready;
        dec_s      = decode_f(in_instr[12:8], sel_bits_s, sel_en_s);
    end

    // Output holding register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid_r      <= 1'b0;
            out_sm_r         <= '0;
            out_op_r         <= 3'd0;
            out_op1_r        <= 3'd0;
            out_op2_r        <= 5'd0;
            out_side_set_r   <= 5'd0;
            out_side_valid_r <= 1'b0;
            out_delay_r      <= 5'd0;
        end else if (accept_s) begin
            out_valid_r      <= 1'b1;
            out_sm_r         <= in_sm;
            out_op_r         <= in_instr[15:13];
            out_op1_r        <= in_instr[7:5];
            out_op2_r        <= in_instr[4:0];
            out_side_set_r   <= dec_s.side_set;
            out_side_valid_r <= dec_s.side_valid;
            out_delay_r      <= dec_s.delay;
        end else if (xfer_s) begin
            out_valid_r      <= 1'b0;
        end
    end

    // Delay counters: disable wins over a load, a load wins over the countdown.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < NUM_SM; k++) begin
                cnt_r[k] <= 5'd0;
            end
        end else begin
            for (int k = 0; k < NUM_SM; k++) begin
                if (!sm_enable[k]) begin
                    cnt_r[k] <= 5'd0;
                end else if (xfer_s && (out_sm_r == SM_W'(k))) begin
                    cnt_r[k] <= out_delay_r;
                end else if (cnt_r[k] != 5'd0) begin
                    cnt_r[k] <= cnt_r[k] - 5'd1;
                end
            end
        end
    end

    assign in_ready       = in_ready_s;
    assign out_valid      = out_valid_r;
    assign out_sm         = out_sm_r;
    assign out_op         = out_op_r;
    assign out_op1        = out_op1_r;
    assign out_op2        = out_op2_r;
    assign out_side_set   = out_side_set_r;
    assign out_side_valid = out_side_valid_r;
    assign out_delay      = out_delay_r;
    assign sm_busy        = busy_s;

endmodule

// File: tb/tb_pio_decode_stage.sv
// Directed bench for pio_decode_stage: decode fields, handshake, delay counters, reset.
module tb_pio_decode_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [1:0]  in_sm;
    logic [11:0] cfg_sideset_bits;
    logic [3:0]  cfg_sideset_en;
    logic [3:0]  sm_enable;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_sm;
    logic [2:0]  out_op;
    logic [2:0]  out_op1;
    logic [4:0]  out_op2;
    logic [4:0]  out_side_set;
    logic        out_side_valid;
    logic [4:0]  out_delay;
    logic [3:0]  sm_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_decode_stage #(.NUM_SM(4), .SM_W(2)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_sm(in_sm), .cfg_sideset_bits(cfg_sideset_bits),
        .cfg_sideset_en(cfg_sideset_en), .sm_enable(sm_enable), .out_valid(out_valid),
        .out_ready(out_ready), .out_sm(out_sm), .out_op(out_op), .out_op1(out_op1),
        .out_op2(out_op2), .out_side_set(out_side_set), .out_side_valid(out_side_valid),
        .out_delay(out_delay), .sm_busy(sm_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int sm, input int op, input int op1,
                           input int op2, input int ss, input int sv, input int dly);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".sm"}, 32'(out_sm), 32'(sm));
        chk({tag, ".op"}, 32'(out_op), 32'(op));
        chk({tag, ".op1"}, 32'(out_op1), 32'(op1));
        chk({tag, ".op2"}, 32'(out_op2), 32'(op2));
        chk({tag, ".side_set"}, 32'(out_side_set), 32'(ss));
        chk({tag, ".side_valid"}, 32'(out_side_valid), 32'(sv));
        chk({tag, ".delay"}, 32'(out_delay), 32'(dly));
    endtask

    initial begin
        resetn           = 1'b0;
        in_valid         = 1'b0;
        in_instr         = 16'h0000;
        in_sm            = 2'd0;
        out_ready        = 1'b0;
        sm_enable        = 4'hF;
        // SM3: 7 (clamps to 5), SM2: 0, SM1: 3 with enable, SM0: 2
        cfg_sideset_bits = {3'd7, 3'd0, 3'd3, 3'd2};
        cfg_sideset_en   = 4'b0010;
        tick();
        tick();
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.sm_busy", 32'(sm_busy), 32'd0);
        chk("rst.out_delay", 32'(out_delay), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd0);

        // T1: SM0 S=2 E=0
        resetn   = 1'b1;
        in_valid = 1'b1;
        in_sm    = 2'd0;
        in_instr = 16'hBA43;
        #1;
        chk("t1.in_ready", 32'(in_ready), 32'd1);
        tick();
        chk_out("t1", 0, 5, 2, 3, 3, 1, 2);

        // T5: downstream stall holds the output and blocks other SMs
        in_sm    = 2'd1;
        in_instr = 16'hAA43;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5.stall_in_ready", 32'(in_ready), 32'd0);
            tick();
            chk_out("t5.hold", 0, 5, 2, 3, 3, 1, 2);
        end
        out_ready = 1'b1;
        #1;
        chk("t5.release_in_ready", 32'(in_ready), 32'd1);
        tick();
        // T2 (side-set enable bit clear) accepted in the same cycle as the transfer
        chk_out("t2.aa43", 1, 5, 2, 3, 2, 0, 2);
        chk("t4.busy_t1", 32'(sm_busy), 32'h1);

        // T4: SM0 blocked for its two delay cycles
        in_valid = 1'b0;
        in_sm    = 2'd0;
        #1;
        chk("t4.ready_t1", 32'(in_ready), 32'd0);
        tick();
        chk("t4.out_valid_t2", 32'(out_valid), 32'd0);
        chk("t4.busy_t2", 32'(sm_busy), 32'h3);
        chk("t4.ready_t2", 32'(in_ready), 32'd0);
        tick();
        chk("t4.busy_t3", 32'(sm_busy), 32'h2);
        chk("t4.ready_t3", 32'(in_ready), 32'd1);

        // Delay-0 instruction allows same-SM back-to-back issue
        in_valid = 1'b1;
        in_instr = 16'hE0A5;
        tick();
        chk_out("d0", 0, 7, 5, 5, 0, 1, 0);
        chk("d0.busy", 32'(sm_busy), 32'h0);
        in_instr = 16'hBA43;
        #1;
        chk("d0.b2b_ready", 32'(in_ready), 32'd1);
        tick();
        chk_out("d0.next", 0, 5, 2, 3, 3, 1, 2);
        chk("samesm.blocked", 32'(in_ready), 32'd0);

        // T2: SM1 with side-set enable bit set
        in_sm = 2'd1;
        #1;
        chk("t2.ready", 32'(in_ready), 32'd1);
        tick();
        chk_out("t2.ba43", 1, 5, 2, 3, 2, 1, 2);

        // T3: SM2 S=0, then SM3 clamped to S=5
        in_sm = 2'd2;
        #1;
        chk("t3.ready_sm2", 32'(in_ready), 32'd1);
        tick();
        chk_out("t3.s0", 2, 5, 2, 3, 0, 0, 26);
        in_sm = 2'd3;
        #1;
        chk("t3.ready_sm3", 32'(in_ready), 32'd1);
        tick();
        chk_out("t3.s7", 3, 5, 2, 3, 26, 1, 0);
        chk("t3.busy", 32'(sm_busy), 32'h6);
        in_valid = 1'b0;
        tick();
        chk("t3.out_valid", 32'(out_valid), 32'd0);
        chk("t3.busy_after", 32'(sm_busy), 32'h4);

        // T6: disabling SM2 mid-count clears its counter
        sm_enable = 4'b1011;
        in_sm     = 2'd2;
        #1;
        chk("t6.disabled_ready", 32'(in_ready), 32'd0);
        tick();
        chk("t6.disable_busy", 32'(sm_busy), 32'h0);
        sm_enable = 4'hF;
        #1;
        chk("t6.reenabled_ready", 32'(in_ready), 32'd1);

        // T6: reset with a held output and cnt[2]=9
        in_valid = 1'b1;
        in_instr = 16'h0900;
        tick();
        chk_out("t6.d9", 2, 0, 0, 0, 0, 0, 9);
        in_sm    = 2'd0;
        in_instr = 16'hBA43;
        #1;
        chk("t6.ready_sm0", 32'(in_ready), 32'd1);
        tick();
        chk("t6.busy_pre", 32'(sm_busy), 32'h4);
        chk("t6.valid_pre", 32'(out_valid), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        resetn    = 1'b0;
        #1;
        chk("t6.rst_ready", 32'(in_ready), 32'd0);
        tick();
        chk("t6.rst_valid", 32'(out_valid), 32'd0);
        chk("t6.rst_busy", 32'(sm_busy), 32'h0);
        chk("t6.rst_delay", 32'(out_delay), 32'd0);
        chk("t6.rst_side_set", 32'(out_side_set), 32'd0);
        chk("t6.rst_op", 32'(out_op), 32'd0);
        resetn = 1'b1;
        tick();
        chk("t6.post_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
